apa102_tx: RTL and testbench

Serialises 32-bit LED frames onto the two-wire APA102-style LED strip interface. Sits directly downstream of the clock divider. It samples the divider's square-wave output as a synchronous strobe in the `i_clk` domain, and uses its edges to pace `o_sck`/`o_sdo`. Upstream frame logic feeds it words over a valid/ready handshake. The block adds the strip start frame and end frame around each burst.

---
 rtl/lamp_pkg.sv | 6 +
 rtl/edge_det.sv | 17 +
 rtl/apa102_tx.sv | 112 +++++++++++
 tb/tb_apa102_tx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// lamp_pkg: shared FSM state type and frame-size constants for the LED strip transmitter
package lamp_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, WAIT, END} state_t;
    localparam int c_word_bits  = 32;
    localparam int c_start_bits = 32;
endpackage

// File: rtl/edge_det.sv
// edge_det: registers a level and reports its rising and falling edges
module edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_q;
    // previous level of the input, one i_clk cycle old
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= 1'b0;
        else          r_q <= i_d;
    end
    assign o_rise = i_d & ~r_q;
    assign o_fall = ~i_d & r_q;
endmodule

// File: rtl/apa102_tx.sv
// apa102_tx: frames LED words with start/end frames and paces them onto o_sck/o_sdo
module apa102_tx
    import lamp_pkg::*;
#(
    parameter int c_end_bits = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sck_ref,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_sck,
    output logic        o_sdo,
    output logic        o_busy
);
    localparam int c_cnt_w = $clog2(c_end_bits > c_word_bits ? c_end_bits : c_word_bits);
    localparam logic [c_cnt_w-1:0] c_cnt_start = c_cnt_w'(c_start_bits - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_word  = c_cnt_w'(c_word_bits - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_end   = c_cnt_w'(c_end_bits - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    state_t                 r_state, w_state;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt;
    logic [c_word_bits-1:0] r_data, w_data;
    logic r_last, w_last, r_pend, w_pend, r_sck, w_sck, r_sdo, w_sdo, r_busy, w_busy;
    logic w_rise, w_fall, w_shift, w_bit, w_accept;

    edge_det u_edge (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_sck_ref),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // state register; reset abandons any partial frame without an end frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_pend  <= 1'b0;
            r_sck   <= 1'b0;
            r_sdo   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_data  <= w_data;
            r_last  <= w_last;
            r_pend  <= w_pend;
            r_sck   <= w_sck;
            r_sdo   <= w_sdo;
            r_busy  <= w_busy;
        end
    end

    // next state: bits are presented on fall and clocked out on the following rise
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_data   = r_data;
        w_last   = r_last;
        w_pend   = r_pend;
        w_sck    = r_sck;
        w_sdo    = r_sdo;
        w_busy   = r_busy;
        w_shift  = (r_state == START) || (r_state == DATA) || (r_state == END);
        w_bit    = (r_state == DATA) ? r_data[c_word_bits-1] : (r_state == END);
        o_ready  = (r_state == IDLE) || (r_state == WAIT);
        w_accept = i_valid && o_ready;
        if (w_accept) begin
            w_data  = i_data;
            w_last  = i_last;
            w_cnt   = (r_state == IDLE) ? c_cnt_start : c_cnt_word;
            w_state = (r_state == IDLE) ? START : DATA;
            w_busy  = 1'b1;
        end
        if (w_fall) begin
            w_sck = 1'b0;
            if (w_shift) begin
                w_sdo  = w_bit;
                w_pend = 1'b1;
            end
        end else if (w_rise && r_pend && w_shift) begin
            w_sck  = 1'b1;
            w_pend = 1'b0;
            w_cnt  = r_cnt - c_cnt_one;
            if (r_state == DATA) w_data = r_data << 1;
            if (r_cnt == '0) begin
                w_cnt = '0;
                if (r_state == START) begin
                    w_state = DATA;
                    w_cnt   = c_cnt_word;
                end else if (r_state == DATA) begin
                    w_state = r_last ? END : WAIT;
                    w_cnt   = r_last ? c_cnt_end : '0;
                end else begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                end
            end
        end
    end

    assign o_sck  = r_sck;
    assign o_sdo  = r_sdo;
    assign o_busy = r_busy;
endmodule

// File: tb/tb_apa102_tx.sv
// tb_apa102_tx: scenario tasks checking the strip bit stream against a frame-level model
module tb_apa102_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck_ref = 1'b0;
    logic        valid = 1'b0;
    logic        valid1 = 1'b0;
    logic [31:0] data = '0;
    logic        last = 1'b0;
    logic        ready, sck, sdo, busy;
    logic        ready1, sck1, sdo1, busy1;

    int     errors = 0;
    int     checks = 0;
    bit     ref_run = 1'b1;
    bit     q0[$];
    bit     q1[$];
    bit     exp_q[$];
    int     rises0, rises1, rdy_rises;
    longint t_first, t_last, t_acc, gap_min, gap_max;
    logic [31:0] words [4];

    apa102_tx #(.c_end_bits(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sck_ref(sck_ref), .i_valid(valid),
        .i_data(data), .i_last(last), .o_ready(ready), .o_sck(sck), .o_sdo(sdo), .o_busy(busy)
    );

    apa102_tx #(.c_end_bits(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sck_ref(sck_ref), .i_valid(valid1),
        .i_data(data), .i_last(last), .o_ready(ready1), .o_sck(sck1), .o_sdo(sdo1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    initial begin : refgen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (ref_run) begin
                ph++;
                if (ph == 4) begin
                    ph = 0;
                    sck_ref = ~sck_ref;
                end
            end
        end
    end

    initial begin : mon
        logic p0, p1, pr;
        p0 = 1'b0;
        p1 = 1'b0;
        pr = 1'b1;
        forever begin
            @(negedge clk);
            if (sck === 1'b1 && p0 !== 1'b1) begin
                q0.push_back(sdo);
                if (rises0 > 0) begin
                    if ($time - t_last < gap_min) gap_min = $time - t_last;
                    if ($time - t_last > gap_max) gap_max = $time - t_last;
                end else t_first = $time;
                t_last = $time;
                rises0++;
            end
            if (sck1 === 1'b1 && p1 !== 1'b1) begin
                q1.push_back(sdo1);
                rises1++;
            end
            if (ready === 1'b1 && pr !== 1'b1) rdy_rises++;
            p0 = sck;
            p1 = sck1;
            pr = ready;
        end
    end

    task automatic clear_mon();
        q0.delete();
        q1.delete();
        rises0 = 0;
        rises1 = 0;
        rdy_rises = 0;
        gap_min = 64'd1_000_000;
        gap_max = 0;
    endtask

    function automatic int first_diff(input bit a[$], input bit b[$]);
        if (a.size() != b.size()) return -2;
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic build_exp(input int n, input int endb);
        exp_q.delete();
        repeat (32) exp_q.push_back(1'b0);
        for (int k = 0; k < n; k++)
            for (int b = 31; b >= 0; b--) exp_q.push_back(words[k][b]);
        repeat (endb) exp_q.push_back(1'b1);
    endtask

    task automatic wait_idle(input int which);
        int c;
        c = 0;
        @(posedge clk);
        #2;
        while (((which == 0) ? busy : busy1) && c < 5000) begin
            @(posedge clk);
            #2;
            c++;
        end
        if ((which == 0) ? busy : busy1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: dut%0d still busy after %0d cycles, required idle", which, c);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic send_words(input int n, input int stall);
        int r, c;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k > 0 && stall > 0) begin
                valid = 1'b0;
                c = 0;
                while (!ready && c < 3000) begin
                    @(negedge clk);
                    c++;
                end
                #1;
                r = rises0;
                repeat (stall) @(negedge clk);
                #1;
                checks++;
                if (rises0 !== r) begin
                    errors++;
                    $display("FAIL stall_no_rises: saw %0d rises during stall, required 0", rises0 - r);
                end
                checks++;
                if (sck !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_sck_low: o_sck=%b at end of stall, required 0", sck);
                end
                @(negedge clk);
            end
            data = words[k];
            last = (k == n - 1);
            valid = 1'b1;
            c = 0;
            while (!ready && c < 3000) begin
                @(negedge clk);
                c++;
            end
            if (!ready) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: word %0d not accepted, o_ready=%b required 1", k, ready);
            end
            if (k == 0) t_acc = $time + 5;
            @(negedge clk);
        end
        valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b, required 0", sck); end
        checks++;
        if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b, required 0", sdo); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int d;
        words[0] = 32'hE1FF0000;
        clear_mon();
        send_words(1, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b after accept, required 1", busy); end
        wait_idle(0);
        build_exp(1, 32);
        checks++;
        if (rises0 !== 96) begin errors++; $display("FAIL single_rises: got %0d, required 96", rises0); end
        d = first_diff(q0, exp_q);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL single_stream: diff at %0d, got %0d bits, required %0d", d, q0.size(), exp_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", busy); end
        checks++;
        if (t_first - t_acc > 145) begin errors++; $display("FAIL single_latency: got %0d ns, required <= 145 ns", t_first - t_acc); end
    endtask

    task automatic test_back_to_back();
        int d;
        for (int k = 0; k < 3; k++) words[k] = $urandom;
        clear_mon();
        send_words(3, 0);
        wait_idle(0);
        build_exp(3, 32);
        checks++;
        if (rises0 !== 160) begin errors++; $display("FAIL b2b_rises: got %0d, required 160", rises0); end
        d = first_diff(q0, exp_q);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL b2b_stream: diff at %0d, got %0d bits, required %0d", d, q0.size(), exp_q.size()); end
        checks++;
        if (rdy_rises !== 3) begin errors++; $display("FAIL b2b_ready_pulses: got %0d rises of o_ready, required 3", rdy_rises); end
        checks++;
        if (gap_min !== 80 || gap_max !== 80) begin errors++; $display("FAIL b2b_gap: got %0d..%0d ns, required 80", gap_min, gap_max); end
    endtask

    task automatic test_stall();
        int d;
        for (int k = 0; k < 2; k++) words[k] = $urandom;
        clear_mon();
        send_words(2, 100);
        wait_idle(0);
        build_exp(2, 32);
        checks++;
        if (rises0 !== 128) begin errors++; $display("FAIL stall_rises: got %0d, required 128", rises0); end
        d = first_diff(q0, exp_q);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL stall_stream: diff at %0d, got %0d bits, required %0d", d, q0.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int c, d;
        words[0] = $urandom;
        clear_mon();
        send_words(1, 0);
        c = 0;
        while (rises0 < 42 && c < 3000) begin
            @(posedge clk);
            #2;
            c++;
        end
        checks++;
        if (rises0 < 42) begin errors++; $display("FAIL rmid_progress: got %0d rises, required 42", rises0); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sck !== 1'b0) begin errors++; $display("FAIL rmid_sck: got %b, required 0", sck); end
        checks++;
        if (sdo !== 1'b0) begin errors++; $display("FAIL rmid_sdo: got %b, required 0", sdo); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b, required 1", ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        words[0] = $urandom;
        clear_mon();
        send_words(1, 0);
        wait_idle(0);
        build_exp(1, 32);
        checks++;
        if (rises0 !== 96) begin errors++; $display("FAIL rmid_rises: got %0d, required 96", rises0); end
        d = first_diff(q0, exp_q);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL rmid_stream: diff at %0d, got %0d bits, required %0d", d, q0.size(), exp_q.size()); end
    endtask

    task automatic test_static_ref();
        int c, d, r;
        logic s;
        words[0] = $urandom;
        clear_mon();
        send_words(1, 0);
        c = 0;
        while (rises0 < 40 && c < 3000) begin
            @(posedge clk);
            #2;
            c++;
        end
        ref_run = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        r = rises0;
        s = sck;
        repeat (50) @(posedge clk);
        #2;
        checks++;
        if (rises0 !== r || sck !== s) begin errors++; $display("FAIL static_hold: %0d rises, o_sck %b->%b, required none", rises0 - r, s, sck); end
        ref_run = 1'b1;
        wait_idle(0);
        build_exp(1, 32);
        checks++;
        if (rises0 !== 96) begin errors++; $display("FAIL static_rises: got %0d, required 96", rises0); end
        d = first_diff(q0, exp_q);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL static_stream: diff at %0d, got %0d bits, required %0d", d, q0.size(), exp_q.size()); end
    endtask

    task automatic test_end_one();
        int d;
        words[0] = $urandom;
        clear_mon();
        @(negedge clk);
        data = words[0];
        last = 1'b1;
        valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        last = 1'b0;
        wait_idle(1);
        build_exp(1, 1);
        checks++;
        if (rises1 !== 65) begin errors++; $display("FAIL end1_rises: got %0d, required 65", rises1); end
        d = first_diff(q1, exp_q);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL end1_stream: diff at %0d, got %0d bits, required %0d", d, q1.size(), exp_q.size()); end
        checks++;
        if (q1.size() == 0 || q1[q1.size()-1] !== 1'b1) begin errors++; $display("FAIL end1_last_bit: got %0d bits, final bit required 1", q1.size()); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_static_ref();
        test_end_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
